// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types for alu_seq_core and its multiplier sub-module:
//   alu_op_e    - 3-bit opcode encoding seen on the request channel
//   alu_state_e - control FSM state (also exported on the debug port)
//   alu_flags_t - registered flag vector returned with each result
// No ports (package).
// -----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SHL = 3'b101,
        ALU_SHR = 3'b110,
        ALU_MUL = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    typedef struct packed {
        logic carry;
        logic ovf;
        logic zero;
        logic err;
    } alu_flags_t;

endpackage

// File: rtl/alu_seq_core_if.sv
// -----------------------------------------------------------------------------
// alu_seq_core_if
// Request/response bundle of alu_seq_core.
//   Request  : in_valid, in_ready, op, a, b
//   Response : out_valid, out_ready, result, result_hi, carry, ovf, zero, err
// Modports:
//   master - the requester/consumer (drives the request, accepts the result)
//   slave  - the ALU core
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both 1. The producer keeps its payload stable while valid=1 and ready=0;
// ready may depend on state only, never combinationally on valid.
// -----------------------------------------------------------------------------
interface alu_seq_core_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             carry;
    logic             ovf;
    logic             zero;
    logic             err;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, result_hi, carry, ovf, zero, err
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, result_hi, carry, ovf, zero, err
    );
endinterface

// File: rtl/alu_mul_iter.sv
// -----------------------------------------------------------------------------
// alu_mul_iter
// Iterative unsigned shift-add multiplier, one partial product per cycle,
// scanning the multiplier LSB first. Only instantiated when ALU_MUL_EN is set.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   start_i     - load operands, clear accumulator and counter
//   a_i, b_i    - multiplicand / multiplier, sampled on start_i
//   done_o      - one-cycle pulse: product_o holds the full product
//   product_o   - 2*WIDTH-bit product
// A start lands on edge 0; edges 1..WIDTH each add one partial product, so
// done_o is high in the cycle after edge WIDTH.
// -----------------------------------------------------------------------------
module alu_mul_iter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   product_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start_i) begin
            mcand_d  = {{WIDTH{1'b0}}, a_i};
            mplier_d = b_i;
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            if (cnt_q != LAST) begin
                // Multiplicand is pre-shifted each step so bit i of b adds a<<i.
                acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
            end else begin
                // Product was presented for one cycle; go quiet.
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    assign done_o    = busy_q && (cnt_q == LAST);
    assign product_o = acc_q;

endmodule

// File: rtl/alu_seq_core.sv
// -----------------------------------------------------------------------------
// alu_seq_core
// Handshaked ALU: accepts one operation over the request channel, returns the
// registered result and flags over the response channel.
// Ports:
//   clk         - rising-edge clock
//   rst_n       - asynchronous active-low reset
//   bus         - alu_seq_core_if.slave (request/response channels)
//   dbg_state_o - current FSM state, for observation only
// Parameters:
//   WIDTH       - operand/result width (>= 2)
//   CNT_W       - derived counter width, do not override
// Build option:
//   ALU_MUL_EN  - when defined, op 111 runs the iterative multiplier
//                 (WIDTH+1 cycles). When undefined, op 111 completes in one
//                 cycle with result=result_hi=0, zero=1, err=1.
// FSM: IDLE (in_ready=1) -> [MUL] -> DONE (out_valid=1) -> IDLE on out_ready.
// -----------------------------------------------------------------------------
module alu_seq_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_seq_core_if.slave bus,
    output alu_state_e   dbg_state_o
);

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    alu_flags_t       flags_q, flags_d;

    alu_op_e          op_w;
    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;
    logic [CNT_W-2:0] shamt_w;
    logic [WIDTH-1:0] alu_res_w;
    logic             alu_carry_w;
    logic             alu_ovf_w;
    logic             accept_w;

    assign op_w     = alu_op_e'(bus.op);
    assign accept_w = bus.in_valid && (state_q == ST_IDLE);

`ifdef ALU_MUL_EN
    logic               mul_start_w;
    logic               mul_done_w;
    logic [2*WIDTH-1:0] mul_product_w;

    assign mul_start_w = accept_w && (op_w == ALU_MUL);

    alu_mul_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (mul_start_w),
        .a_i       (bus.a),
        .b_i       (bus.b),
        .done_o    (mul_done_w),
        .product_o (mul_product_w)
    );
`endif

    // Single-cycle datapath, evaluated on the live request operands.
    always_comb begin
        sum_w       = {1'b0, bus.a} + {1'b0, bus.b};
        diff_w      = {1'b0, bus.a} - {1'b0, bus.b};
        shamt_w     = bus.b[CNT_W-2:0];
        alu_res_w   = '0;
        alu_carry_w = 1'b0;
        alu_ovf_w   = 1'b0;
        case (op_w)
            ALU_ADD: begin
                alu_res_w   = sum_w[WIDTH-1:0];
                alu_carry_w = sum_w[WIDTH];
                alu_ovf_w   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                              (sum_w[WIDTH-1] != bus.a[WIDTH-1]);
            end
            ALU_SUB: begin
                alu_res_w   = diff_w[WIDTH-1:0];
                // The extra MSB of the difference is the unsigned borrow.
                alu_carry_w = diff_w[WIDTH];
                // Subtracting b is adding -b, whose sign is the inverse of b's.
                alu_ovf_w   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                              (diff_w[WIDTH-1] != bus.a[WIDTH-1]);
            end
            ALU_AND: alu_res_w = bus.a & bus.b;
            ALU_OR:  alu_res_w = bus.a | bus.b;
            ALU_XOR: alu_res_w = bus.a ^ bus.b;
            ALU_SHL: alu_res_w = bus.a << shamt_w;
            ALU_SHR: alu_res_w = bus.a >> shamt_w;
            default: ;
        endcase
    end

    // Next-state and output-register logic.
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        flags_d     = flags_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_w) begin
                    if (op_w == ALU_MUL) begin
`ifdef ALU_MUL_EN
                        state_d = ST_MUL;
`else
                        result_d      = '0;
                        result_hi_d   = '0;
                        flags_d.carry = 1'b0;
                        flags_d.ovf   = 1'b0;
                        flags_d.zero  = 1'b1;
                        flags_d.err   = 1'b1;
                        state_d       = ST_DONE;
`endif
                    end else begin
                        result_d      = alu_res_w;
                        result_hi_d   = '0;
                        flags_d.carry = alu_carry_w;
                        flags_d.ovf   = alu_ovf_w;
                        // zero reflects the value being registered.
                        flags_d.zero  = (alu_res_w == '0);
                        flags_d.err   = 1'b0;
                        state_d       = ST_DONE;
                    end
                end
            end
`ifdef ALU_MUL_EN
            ST_MUL: begin
                if (mul_done_w) begin
                    result_d      = mul_product_w[WIDTH-1:0];
                    result_hi_d   = mul_product_w[2*WIDTH-1:WIDTH];
                    flags_d.carry = 1'b0;
                    flags_d.ovf   = 1'b0;
                    flags_d.zero  = (mul_product_w == '0);
                    flags_d.err   = 1'b0;
                    state_d       = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            result_hi_q <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            flags_q     <= flags_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.result    = result_q;
    assign bus.result_hi = result_hi_q;
    assign bus.carry     = flags_q.carry;
    assign bus.ovf       = flags_q.ovf;
    assign bus.zero      = flags_q.zero;
    assign bus.err       = flags_q.err;
    assign dbg_state_o   = state_q;

endmodule
